flit_reader: RTL and testbench

Downstream consumer of the 8-slot, 34-bit flit FIFO. Pops flits from the FIFO's first-word-fall-through output and checks the head/body/tail packet protocol. Extracts the destination coordinates from each head flit and presents payload words to the router crossbar stage over a registered valid/ready interface.

---
 rtl/noc_pkg.sv | 20 ++
 rtl/sat_counter.sv | 14 +
 rtl/flit_reader.sv | 109 ++++++++++
 tb/tb_flit_reader.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// noc_pkg: shared flit format, flit types and reader FSM states for the NoC router slice.
package noc_pkg;
  localparam int FLIT_W = 34;
  localparam int DEF_X_W = 2;
  localparam int DEF_Y_W = 2;
  typedef enum logic [1:0] {
    HEAD_TAIL = 2'b00,
    HEAD      = 2'b01,
    BODY      = 2'b10,
    TAIL      = 2'b11
  } flit_type_e;
  typedef struct packed {
    flit_type_e  ftype;
    logic [31:0] payload;
  } flit_t;
  typedef enum logic {IDLE, PKT} rd_state_e;
  function automatic logic is_head(input flit_type_e t);
    return !t[1];
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with async active-low reset.
// Ports: clk, arst (active-low async), inc (count enable), cnt (value, sticks at all-ones).
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge arst)
    if (!arst) cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + W'(1);
endmodule

// File: rtl/flit_reader.sv
// flit_reader: pops a FWFT flit FIFO, checks head/body/tail protocol, forwards payloads on registered valid/ready.
// Ports: clk, arst (active-low async); fifo_data_i/fifo_empty_i/fifo_read_o FIFO side;
//   valid_o/ready_i/data_o/sop_o/eop_o/dest_x_o/dest_y_o crossbar side; error_o violation pulse;
//   pkt_cnt_o/err_cnt_o live only when FLIT_READER_STATS_EN is defined, otherwise tied to 0.
module flit_reader
  import noc_pkg::*;
#(
  parameter int FLIT_W    = noc_pkg::FLIT_W,
  parameter int X_W       = DEF_X_W,
  parameter int Y_W       = DEF_Y_W,
  parameter int MAX_FLITS = 16
) (
  input  logic              clk,
  input  logic              arst,
  input  logic [FLIT_W-1:0] fifo_data_i,
  input  logic              fifo_empty_i,
  output logic              fifo_read_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [31:0]       data_o,
  output logic              sop_o,
  output logic              eop_o,
  output logic [X_W-1:0]    dest_x_o,
  output logic [Y_W-1:0]    dest_y_o,
  output logic              error_o,
  output logic [15:0]       pkt_cnt_o,
  output logic [7:0]        err_cnt_o
);
  localparam logic [4:0] MAX_C = 5'(MAX_FLITS);
  flit_t f;
  rd_state_e state_q, state_d;
  logic [4:0] cnt_q, cnt_d, cnt_nxt;
  logic [31:0] data_d;
  logic [X_W-1:0] dx_d;
  logic [Y_W-1:0] dy_d;
  logic valid_d, sop_d, eop_d, err_d, force_eop;
  assign f = flit_t'(fifo_data_i);
  // no pops while in reset so a non-empty FIFO is left untouched
  assign fifo_read_o = arst && !fifo_empty_i && (!valid_o || ready_i);
  assign cnt_nxt = cnt_q + 5'd1;
  always_comb begin
    state_d = state_q;
    valid_d = valid_o && !ready_i;
    data_d = data_o;
    sop_d = sop_o;
    eop_d = eop_o;
    dx_d = dest_x_o;
    dy_d = dest_y_o;
    cnt_d = cnt_q;
    err_d = 1'b0;
    force_eop = 1'b0;
    if (fifo_read_o) begin
      if (is_head(f.ftype)) begin
        // a head inside a packet aborts it and starts the new one
        valid_d = 1'b1;
        data_d = f.payload;
        sop_d = 1'b1;
        eop_d = f.ftype == HEAD_TAIL;
        dx_d = f.payload[X_W-1:0];
        dy_d = f.payload[X_W+Y_W-1:X_W];
        cnt_d = 5'd1;
        state_d = (f.ftype == HEAD) ? PKT : IDLE;
        err_d = state_q == PKT;
      end else if (state_q == IDLE) begin
        valid_d = 1'b0;
        err_d = 1'b1;
      end else begin
        force_eop = f.ftype == BODY && cnt_nxt == MAX_C;
        valid_d = 1'b1;
        data_d = f.payload;
        sop_d = 1'b0;
        eop_d = f.ftype == TAIL || force_eop;
        cnt_d = cnt_nxt;
        err_d = force_eop;
        state_d = eop_d ? IDLE : PKT;
      end
    end
  end
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      valid_o <= 1'b0;
      data_o <= '0;
      sop_o <= 1'b0;
      eop_o <= 1'b0;
      dest_x_o <= '0;
      dest_y_o <= '0;
      error_o <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      valid_o <= valid_d;
      data_o <= data_d;
      sop_o <= sop_d;
      eop_o <= eop_d;
      dest_x_o <= dx_d;
      dest_y_o <= dy_d;
      error_o <= err_d;
    end
  end
`ifdef FLIT_READER_STATS_EN
  sat_counter #(.W(16)) u_pkt_cnt (.clk(clk), .arst(arst), .inc(valid_o && ready_i && eop_o), .cnt(pkt_cnt_o));
  sat_counter #(.W(8)) u_err_cnt (.clk(clk), .arst(arst), .inc(err_d), .cnt(err_cnt_o));
`else
  assign pkt_cnt_o = '0;
  assign err_cnt_o = '0;
`endif
endmodule

// File: tb/tb_flit_reader.sv
// tb_flit_reader: randomized and directed checks of flit_reader against a packet-level reference model.
module tb_flit_reader;
  import noc_pkg::*;
  localparam int MAXF = 16;
  typedef struct packed {
    logic [31:0] d;
    logic        sop;
    logic        eop;
    logic [1:0]  x;
    logic [1:0]  y;
  } word_t;
  logic clk = 1'b0, arst = 1'b0, ready_i = 1'b0, fifo_empty_i = 1'b1;
  logic [33:0] fifo_data_i = '0;
  logic fifo_read_o, valid_o, sop_o, eop_o, error_o;
  logic [31:0] data_o;
  logic [1:0] dest_x_o, dest_y_o;
  logic [15:0] pkt_cnt_o;
  logic [7:0] err_cnt_o;
  int vectors = 0, miscompares = 0;
  int err_seen = 0, m_err = 0, m_pkt = 0, m_n = 0;
  bit m_in = 1'b0;
  logic [1:0] m_x = '0, m_y = '0;
  logic [33:0] fq[$];
  word_t exp_q[$];
  word_t w;
  flit_reader dut (
    .clk(clk), .arst(arst), .fifo_data_i(fifo_data_i), .fifo_empty_i(fifo_empty_i),
    .fifo_read_o(fifo_read_o), .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
    .sop_o(sop_o), .eop_o(eop_o), .dest_x_o(dest_x_o), .dest_y_o(dest_y_o),
    .error_o(error_o), .pkt_cnt_o(pkt_cnt_o), .err_cnt_o(err_cnt_o)
  );
  always #5 clk = ~clk;
  task automatic refresh();
    fifo_empty_i = fq.size() == 0;
    fifo_data_i = (fq.size() != 0) ? fq[0] : '0;
  endtask
  // FWFT FIFO: pop on the edge where the strobe was high, then present the new head
  always @(posedge clk) begin
    if (fifo_read_o && fq.size() != 0) fq.delete(0);
    #1 refresh();
  end
  // reference model: derives the expected word stream from packet rules at push time
  task automatic send(input flit_type_e t, input logic [31:0] p);
    fq.push_back({t, p});
    refresh();
    if (t == HEAD || t == HEAD_TAIL) begin
      if (m_in) m_err++;
      m_x = p[1:0];
      m_y = p[3:2];
      m_in = (t == HEAD);
      m_n = 1;
      exp_q.push_back('{d: p, sop: 1'b1, eop: t == HEAD_TAIL, x: m_x, y: m_y});
      if (t == HEAD_TAIL) m_pkt++;
    end else if (!m_in) begin
      m_err++;
    end else begin
      m_n++;
      if (t == TAIL || m_n == MAXF) begin
        exp_q.push_back('{d: p, sop: 1'b0, eop: 1'b1, x: m_x, y: m_y});
        m_in = 1'b0;
        m_pkt++;
        if (t == BODY) m_err++;
      end else begin
        exp_q.push_back('{d: p, sop: 1'b0, eop: 1'b0, x: m_x, y: m_y});
      end
    end
  endtask
  function automatic logic [15:0] exp_pkt();
`ifdef FLIT_READER_STATS_EN
    return (m_pkt > 65535) ? 16'hFFFF : 16'(m_pkt);
`else
    return 16'd0;
`endif
  endfunction
  function automatic logic [7:0] exp_errc();
`ifdef FLIT_READER_STATS_EN
    return (m_err > 255) ? 8'hFF : 8'(m_err);
`else
    return 8'd0;
`endif
  endfunction
  // scoreboard: every accepted word must be the next one the model predicted
  always @(negedge clk) begin
    if (error_o) err_seen++;
    if (valid_o && ready_i) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_word got data=%h sop=%b eop=%b", data_o, sop_o, eop_o);
      end else begin
        w = exp_q.pop_front();
        if ({data_o, sop_o, eop_o, dest_x_o, dest_y_o} !== w) begin
          miscompares++;
          $display("FAIL word got d=%h sop=%b eop=%b x=%0d y=%0d exp d=%h sop=%b eop=%b x=%0d y=%0d",
                   data_o, sop_o, eop_o, dest_x_o, dest_y_o, w.d, w.sop, w.eop, w.x, w.y);
        end
      end
    end
  end
  task automatic drain();
    @(posedge clk);
    #2 ready_i = 1'b1;
    for (int i = 0; i < 300 && (fq.size() != 0 || valid_o); i++) @(negedge clk);
    repeat (2) @(negedge clk);
    vectors++;
    if (fq.size() != 0 || valid_o) begin
      miscompares++;
      $display("FAIL drain_timeout fifo=%0d valid=%b", fq.size(), valid_o);
    end
  endtask
  task automatic test_reset();
    fq.push_back({BODY, 32'hDEAD_BEEF});
    refresh();
    repeat (10) @(negedge clk);
    vectors += 3;
    if ({valid_o, sop_o, eop_o, error_o} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_flags got %b exp 0000", {valid_o, sop_o, eop_o, error_o});
    end
    if ({data_o, dest_x_o, dest_y_o, pkt_cnt_o, err_cnt_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_values got d=%h x=%0d y=%0d pc=%0d ec=%0d exp 0", data_o, dest_x_o, dest_y_o, pkt_cnt_o, err_cnt_o);
    end
    if (fifo_read_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_read got %b exp 0", fifo_read_o);
    end
    fq.delete();
    refresh();
    @(posedge clk);
    #2 arst = 1'b1;
  endtask
  task automatic test_basic();
    @(posedge clk);
    #2 ready_i = 1'b1;
    send(HEAD, 32'h0000_0006);
    send(BODY, 32'hA5A5_A5A5);
    send(TAIL, 32'h1234_5678);
    for (int i = 0; i < 10 && !valid_o; i++) @(negedge clk);
    vectors++;
    if (dest_x_o !== 2'd2 || dest_y_o !== 2'd1 || sop_o !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_head got x=%0d y=%0d sop=%b exp x=2 y=1 sop=1", dest_x_o, dest_y_o, sop_o);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (valid_o !== (i < 2)) begin
        miscompares++;
        $display("FAIL basic_valid_%0d got %b exp %b", i, valid_o, i < 2);
      end
    end
    drain();
    vectors += 2;
    if (exp_q.size() != 0 || err_seen != m_err) begin
      miscompares++;
      $display("FAIL basic_stream left=%0d errors got %0d exp %0d", exp_q.size(), err_seen, m_err);
    end
    if (pkt_cnt_o !== exp_pkt() || err_cnt_o !== exp_errc()) begin
      miscompares++;
      $display("FAIL basic_cnt got pc=%0d ec=%0d exp pc=%0d ec=%0d", pkt_cnt_o, err_cnt_o, exp_pkt(), exp_errc());
    end
  endtask
  task automatic test_backpressure();
    @(posedge clk);
    #2 ready_i = 1'b0;
    send(HEAD, 32'h0000_000B);
    send(BODY, 32'h5A5A_0001);
    send(TAIL, 32'h5A5A_0002);
    for (int i = 0; i < 10 && !valid_o; i++) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (valid_o !== 1'b1 || fifo_read_o !== 1'b0 || data_o !== 32'h0000_000B) begin
        miscompares++;
        $display("FAIL bp_hold_%0d got v=%b rd=%b d=%h exp v=1 rd=0 d=0000000b", i, valid_o, fifo_read_o, data_o);
      end
    end
    drain();
    vectors += 2;
    if (exp_q.size() != 0 || err_seen != m_err) begin
      miscompares++;
      $display("FAIL bp_stream left=%0d errors got %0d exp %0d", exp_q.size(), err_seen, m_err);
    end
    if (pkt_cnt_o !== exp_pkt()) begin
      miscompares++;
      $display("FAIL bp_pkt_cnt got %0d exp %0d", pkt_cnt_o, exp_pkt());
    end
  endtask
  task automatic test_body_idle();
    int e0 = err_seen;
    @(posedge clk);
    #2 send(BODY, $urandom);
    @(negedge clk);
    vectors++;
    if (fifo_read_o !== 1'b1) begin
      miscompares++;
      $display("FAIL idle_pop got %b exp 1", fifo_read_o);
    end
    @(negedge clk);
    vectors++;
    if (error_o !== 1'b1 || valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_err got err=%b v=%b exp err=1 v=0", error_o, valid_o);
    end
    @(negedge clk);
    vectors++;
    if (error_o !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_pulse got %b exp 0", error_o);
    end
    drain();
    vectors += 2;
    if (err_seen - e0 != 1 || fq.size() != 0) begin
      miscompares++;
      $display("FAIL idle_count got %0d errors fifo=%0d exp 1 errors fifo=0", err_seen - e0, fq.size());
    end
    if (err_cnt_o !== exp_errc()) begin
      miscompares++;
      $display("FAIL idle_err_cnt got %0d exp %0d", err_cnt_o, exp_errc());
    end
  endtask
  task automatic test_max_flits();
    int e0 = err_seen;
    @(posedge clk);
    #2 send(HEAD, 32'h0000_0009);
    for (int i = 0; i < 20; i++) send(BODY, $urandom);
    drain();
    vectors += 3;
    if (err_seen - e0 != 6) begin
      miscompares++;
      $display("FAIL max_errors got %0d exp 6", err_seen - e0);
    end
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL max_stream left=%0d exp 0", exp_q.size());
    end
    if (pkt_cnt_o !== exp_pkt() || err_cnt_o !== exp_errc()) begin
      miscompares++;
      $display("FAIL max_cnt got pc=%0d ec=%0d exp pc=%0d ec=%0d", pkt_cnt_o, err_cnt_o, exp_pkt(), exp_errc());
    end
  endtask
  task automatic test_reset_mid();
    @(posedge clk);
    #2 ready_i = 1'b0;
    send(HEAD, 32'h0000_000F);
    for (int i = 0; i < 10 && !valid_o; i++) @(negedge clk);
    @(posedge clk);
    #2 arst = 1'b0;
    #1;
    vectors++;
    if ({valid_o, sop_o, data_o, dest_x_o, dest_y_o} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset got v=%b sop=%b d=%h x=%0d y=%0d exp 0", valid_o, sop_o, data_o, dest_x_o, dest_y_o);
    end
    exp_q.delete();
    m_in = 1'b0;
    m_err = 0;
    m_pkt = 0;
    err_seen = 0;
    @(posedge clk);
    #2 arst = 1'b1;
    send(BODY, 32'h0BAD_0BAD);
    drain();
    vectors += 2;
    if (err_seen != 1 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL mid_next got errors=%0d left=%0d exp errors=1 left=0", err_seen, exp_q.size());
    end
    if (pkt_cnt_o !== exp_pkt() || err_cnt_o !== exp_errc()) begin
      miscompares++;
      $display("FAIL mid_cnt got pc=%0d ec=%0d exp pc=%0d ec=%0d", pkt_cnt_o, err_cnt_o, exp_pkt(), exp_errc());
    end
  endtask
  task automatic test_random();
    int r;
    flit_type_e t;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk);
      #2 ready_i = $urandom_range(0, 3) != 0;
      if (fq.size() < 8 && $urandom_range(0, 1) == 1) begin
        r = $urandom_range(0, 19);
        t = (r < 2) ? HEAD_TAIL : (r < 5) ? HEAD : (r < 16) ? BODY : TAIL;
        send(t, $urandom);
      end
    end
    drain();
    vectors += 2;
    if (exp_q.size() != 0 || err_seen != m_err) begin
      miscompares++;
      $display("FAIL rand_stream left=%0d errors got %0d exp %0d", exp_q.size(), err_seen, m_err);
    end
    if (pkt_cnt_o !== exp_pkt() || err_cnt_o !== exp_errc()) begin
      miscompares++;
      $display("FAIL rand_cnt got pc=%0d ec=%0d exp pc=%0d ec=%0d", pkt_cnt_o, err_cnt_o, exp_pkt(), exp_errc());
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_body_idle();
    test_max_flits();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
